// File: rtl/panda_risc_v_div_pkg.sv
// rtl/panda_risc_v_div_pkg.sv - state encoding, constants and helpers shared by the iterative divider
package panda_risc_v_div_pkg;

  typedef enum logic [1:0] {
    DIV_ST_IDLE  = 2'd0,
    DIV_ST_CALC  = 2'd1,
    DIV_ST_FIXUP = 2'd2,
    DIV_ST_DONE  = 2'd3
  } div_state_e;

  localparam int          DIV_STEPS     = 32;
  localparam logic [4:0]  DIV_CNT_INIT  = 5'(DIV_STEPS - 1);
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  // Operands arrive pre-extended, so the low 32 bits negate cleanly, -2^31 included.
  function automatic logic [31:0] div_mag(input logic [32:0] v);
    return v[32] ? (~v[31:0] + 32'd1) : v[31:0];
  endfunction

endpackage

// File: rtl/panda_risc_v_div_step.sv
// rtl/panda_risc_v_div_step.sv - one combinational restoring-division step on the {remainder, quotient} pair
module panda_risc_v_div_step (
  input  logic [32:0] i_rem,
  input  logic [31:0] i_quot,
  input  logic [31:0] i_divisor,
  output logic [32:0] o_rem,
  output logic [31:0] o_quot
);

  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic        w_unused_rem_msb;

  // The partial remainder stays below the divisor, so its top bit never carries information in.
  assign w_unused_rem_msb = i_rem[32];

  assign w_shift = {i_rem[31:0], i_quot[31]};
  assign w_ge    = (w_shift >= {1'b0, i_divisor});
  assign w_diff  = w_shift - {1'b0, i_divisor};

  assign o_rem  = w_ge ? w_diff : w_shift;
  assign o_quot = {i_quot[30:0], w_ge};

endmodule

// File: rtl/panda_risc_v_div_iter.sv
// rtl/panda_risc_v_div_iter.sv - iterative radix-2 restoring divider EXU, one op in flight
// Optional early completion of trivial divides: PANDA_RISC_V_DIV_EARLY_OUT_EN
module panda_risc_v_div_iter
  import panda_risc_v_div_pkg::*;
#(
  parameter int inst_id_width    = 4,
  parameter int simulation_delay = 1
) (
  input  logic                     clk,
  input  logic                     sys_reset,
  input  logic                     flush_req,
  input  logic [32:0]              s_div_op_a,
  input  logic [32:0]              s_div_op_b,
  input  logic                     s_div_rem_sel,
  input  logic [4:0]               s_div_rd_id,
  input  logic [inst_id_width-1:0] s_div_inst_id,
  input  logic                     s_div_valid,
  output logic                     s_div_ready,
  output logic [31:0]              m_div_wb_data,
  output logic [4:0]               m_div_wb_rd_id,
  output logic [inst_id_width-1:0] m_div_wb_inst_id,
  output logic                     m_div_wb_valid,
  input  logic                     m_div_wb_ready
);

  // Registered updates carry no modelled delay; the parameter keeps dispatch-side instantiations uniform.
  localparam int unused_sim_delay = simulation_delay;

  div_state_e              r_state;
  logic [4:0]              r_cnt;
  logic [32:0]             r_rem;
  logic [31:0]             r_quot;
  logic [31:0]             r_div_mag;
  logic                    r_neg_q;
  logic                    r_neg_r;
  logic                    r_rem_sel;
  logic                    r_b_zero;
  logic [4:0]              r_rd_id;
  logic [inst_id_width-1:0] r_inst_id;
  logic [31:0]             r_wb_data;
  logic                    r_wb_valid;

  logic                    w_accept;
  logic [31:0]             w_a_mag;
  logic [31:0]             w_b_mag;
  logic                    w_b_zero;
  logic [32:0]             w_step_rem;
  logic [31:0]             w_step_quot;
  logic [31:0]             w_quot_fix;
  logic [31:0]             w_rem_fix;
  logic                    w_early_out;
  logic [31:0]             w_early_data;

  assign s_div_ready = (r_state == DIV_ST_IDLE) & ~flush_req;
  assign w_accept    = s_div_valid & s_div_ready;

  assign w_a_mag  = div_mag(s_div_op_a);
  assign w_b_mag  = div_mag(s_div_op_b);
  assign w_b_zero = (s_div_op_b == 33'd0);

  panda_risc_v_div_step u_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_div_mag),
    .o_rem     (w_step_rem),
    .o_quot    (w_step_quot)
  );

  // A zero divisor leaves all-ones in the quotient naturally, but the sign fix must not touch it.
  assign w_quot_fix = r_b_zero ? DIV_ZERO_QUOT : (r_neg_q ? (~r_quot + 32'd1) : r_quot);
  assign w_rem_fix  = r_neg_r ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

`ifdef PANDA_RISC_V_DIV_EARLY_OUT_EN
  assign w_early_out = w_b_zero | (w_b_mag > w_a_mag);
`else
  assign w_early_out = 1'b0;
`endif
  assign w_early_data = s_div_rem_sel ? s_div_op_a[31:0] : (w_b_zero ? DIV_ZERO_QUOT : 32'd0);

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      r_state    <= DIV_ST_IDLE;
      r_cnt      <= 5'd0;
      r_rem      <= 33'd0;
      r_quot     <= 32'd0;
      r_div_mag  <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_rem_sel  <= 1'b0;
      r_b_zero   <= 1'b0;
      r_rd_id    <= 5'd0;
      r_inst_id  <= '0;
      r_wb_data  <= 32'd0;
      r_wb_valid <= 1'b0;
    end else if (flush_req) begin
      r_state    <= DIV_ST_IDLE;
      r_wb_valid <= 1'b0;
    end else begin
      case (r_state)
        DIV_ST_IDLE: begin
          if (w_accept) begin
            r_rem     <= 33'd0;
            r_quot    <= w_a_mag;
            r_div_mag <= w_b_mag;
            r_neg_q   <= s_div_op_a[32] ^ s_div_op_b[32];
            r_neg_r   <= s_div_op_a[32];
            r_rem_sel <= s_div_rem_sel;
            r_b_zero  <= w_b_zero;
            r_rd_id   <= s_div_rd_id;
            r_inst_id <= s_div_inst_id;
            r_cnt     <= DIV_CNT_INIT;
            if (w_early_out) begin
              r_wb_data <= w_early_data;
              r_state   <= DIV_ST_DONE;
            end else begin
              r_state   <= DIV_ST_CALC;
            end
          end
        end
        DIV_ST_CALC: begin
          r_rem  <= w_step_rem;
          r_quot <= w_step_quot;
          r_cnt  <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) begin
            r_state <= DIV_ST_FIXUP;
          end
        end
        DIV_ST_FIXUP: begin
          r_wb_data <= r_rem_sel ? w_rem_fix : w_quot_fix;
          r_state   <= DIV_ST_DONE;
        end
        DIV_ST_DONE: begin
          // First DONE cycle raises valid; ready only matters once the result is presented.
          if (!r_wb_valid) begin
            r_wb_valid <= 1'b1;
          end else if (m_div_wb_ready) begin
            r_wb_valid <= 1'b0;
            r_state    <= DIV_ST_IDLE;
          end
        end
        default: begin
          r_state <= DIV_ST_IDLE;
        end
      endcase
    end
  end

  assign m_div_wb_data    = r_wb_data;
  assign m_div_wb_rd_id   = r_rd_id;
  assign m_div_wb_inst_id = r_inst_id;
  assign m_div_wb_valid   = r_wb_valid;

endmodule

// File: tb/tb_panda_risc_v_div_iter.sv
// tb/tb_panda_risc_v_div_iter.sv - scoreboard bench for the iterative divider
module tb_panda_risc_v_div_iter;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  logic        clk = 1'b0;
  logic        sys_reset;
  logic        flush_req;
  logic [32:0] s_div_op_a;
  logic [32:0] s_div_op_b;
  logic        s_div_rem_sel;
  logic [4:0]  s_div_rd_id;
  logic [3:0]  s_div_inst_id;
  logic        s_div_valid;
  logic        s_div_ready;
  logic [31:0] m_div_wb_data;
  logic [4:0]  m_div_wb_rd_id;
  logic [3:0]  m_div_wb_inst_id;
  logic        m_div_wb_valid;
  logic        m_div_wb_ready;

  always #5 clk = ~clk;

  panda_risc_v_div_iter #(.inst_id_width(4), .simulation_delay(1)) dut (
    .clk              (clk),
    .sys_reset        (sys_reset),
    .flush_req        (flush_req),
    .s_div_op_a       (s_div_op_a),
    .s_div_op_b       (s_div_op_b),
    .s_div_rem_sel    (s_div_rem_sel),
    .s_div_rd_id      (s_div_rd_id),
    .s_div_inst_id    (s_div_inst_id),
    .s_div_valid      (s_div_valid),
    .s_div_ready      (s_div_ready),
    .m_div_wb_data    (m_div_wb_data),
    .m_div_wb_rd_id   (m_div_wb_rd_id),
    .m_div_wb_inst_id (m_div_wb_inst_id),
    .m_div_wb_valid   (m_div_wb_valid),
    .m_div_wb_ready   (m_div_wb_ready)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [3:0]  inst;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   hold_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: RISC-V M divide semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      x, y, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end else begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end
    q  = x / y;
    r  = x % y;
    qv = q;
    rv = r;
    return op[1] ? rv[31:0] : qv[31:0];
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef PANDA_RISC_V_DIV_EARLY_OUT_EN
    longint ma, mb;
    if (b == 32'd0) return 1;
    ma = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
    mb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    return (mb > ma) ? 1 : 34;
`else
    return (op == 2'd0 && a == b) ? 34 : 34;
`endif
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_data, input bit expect_it);
    exp_t e;
    int   w;
    @(posedge clk); #1;
    s_div_op_a    = op[0] ? {1'b0, a} : {a[31], a};
    s_div_op_b    = op[0] ? {1'b0, b} : {b[31], b};
    s_div_rem_sel = op[1];
    s_div_rd_id   = 5'($urandom);
    s_div_inst_id = 4'($urandom);
    s_div_valid   = 1'b1;
    w = 0;
    @(negedge clk);
    while (!s_div_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!s_div_ready) begin
      chk("accept_timeout", 64'(s_div_ready), 64'd1);
      s_div_valid = 1'b0;
      return;
    end
    if (expect_it) begin
      e.data = exp_data;
      e.rd   = s_div_rd_id;
      e.inst = s_div_inst_id;
      e.acc  = cyc + 1;
      e.lat  = ref_latency(op, a, b);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    s_div_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while ((sb_q.size() != 0 || m_div_wb_valid) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk(name, 64'(sb_q.size()), 64'd0);
  endtask

  // Result-side ready: random, or forced low while a hold test runs.
  initial begin
    m_div_wb_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_div_wb_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: checks each presented result once, then stability while stalled.
  bit          in_done = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] snap_data;
  logic [4:0]  snap_rd;
  logic [3:0]  snap_inst;

  always @(negedge clk) begin
    if (sys_reset) begin
      in_done   = 1'b0;
      prev_hold = 1'b0;
    end else if (m_div_wb_valid) begin
      if (prev_hold) begin
        chk("stall_data", 64'(m_div_wb_data), 64'(snap_data));
        chk("stall_rd", 64'(m_div_wb_rd_id), 64'(snap_rd));
        chk("stall_inst", 64'(m_div_wb_inst_id), 64'(snap_inst));
        chk("stall_s_ready", 64'(s_div_ready), 64'd0);
      end
      if (!in_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 64'(m_div_wb_valid), 64'd0);
        end else begin
          chk("data", 64'(m_div_wb_data), 64'(sb_q[0].data));
          chk("rd_id", 64'(m_div_wb_rd_id), 64'(sb_q[0].rd));
          chk("inst_id", 64'(m_div_wb_inst_id), 64'(sb_q[0].inst));
          chk("latency", 64'(cyc - sb_q[0].acc), 64'(sb_q[0].lat));
        end
        in_done = 1'b1;
      end
      if (m_div_wb_ready && !flush_req) begin
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        in_done   = 1'b0;
        prev_hold = 1'b0;
      end else begin
        prev_hold = 1'b1;
        snap_data = m_div_wb_data;
        snap_rd   = m_div_wb_rd_id;
        snap_inst = m_div_wb_inst_id;
      end
    end else begin
      if (in_done) chk("valid_dropped", 64'(m_div_wb_valid), 64'd1);
      in_done   = 1'b0;
      prev_hold = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          w;

    sys_reset     = 1'b1;
    flush_req     = 1'b0;
    s_div_op_a    = '0;
    s_div_op_b    = '0;
    s_div_rem_sel = 1'b0;
    s_div_rd_id   = '0;
    s_div_inst_id = '0;
    s_div_valid   = 1'b0;
    repeat (3) @(posedge clk);
    #1 sys_reset = 1'b0;
    @(negedge clk);
    chk("reset_s_ready", 64'(s_div_ready), 64'd1);
    chk("reset_valid", 64'(m_div_wb_valid), 64'd0);
    chk("reset_data", 64'(m_div_wb_data), 64'd0);
    chk("reset_rd", 64'(m_div_wb_rd_id), 64'd0);
    chk("reset_inst", 64'(m_div_wb_inst_id), 64'd0);

    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    issue(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b1);
    issue(OP_DIV, -32'd7, 32'd2, 32'hFFFF_FFFD, 1'b1);
    issue(OP_REM, -32'd7, 32'd2, 32'hFFFF_FFFF, 1'b1);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    issue(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    issue(OP_REM, -32'd5, 32'd0, 32'hFFFF_FFFB, 1'b1);
    issue(OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1);
    issue(OP_DIV, 32'd7, -32'd2, 32'hFFFF_FFFD, 1'b1);
    issue(OP_REM, 32'd7, -32'd2, 32'd1, 1'b1);
    drain("drain_directed");

    // Stall the result for ten cycles; the monitor checks stability each cycle.
    hold_ready = 1'b1;
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    w = 0;
    while (!m_div_wb_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (10) @(negedge clk);
    chk("hold_valid", 64'(m_div_wb_valid), 64'd1);
    chk("hold_s_ready", 64'(s_div_ready), 64'd0);
    hold_ready = 1'b0;
    drain("drain_hold");

    // Flush mid-calculation, then present a request while flush is still high.
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (15) @(posedge clk);
    #1 flush_req = 1'b1;
    @(negedge clk);
    chk("flush_s_ready_calc", 64'(s_div_ready), 64'd0);
    @(posedge clk); #1;
    s_div_op_a    = 33'd50;
    s_div_op_b    = 33'd5;
    s_div_rem_sel = 1'b0;
    s_div_valid   = 1'b1;
    @(negedge clk);
    chk("flush_s_ready_idle", 64'(s_div_ready), 64'd0);
    @(posedge clk); #1;
    flush_req   = 1'b0;
    s_div_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_flush", 64'(s_div_ready), 64'd1);
    repeat (45) @(negedge clk);
    chk("no_flushed_result", 64'(m_div_wb_valid), 64'd0);
    issue(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b1);
    drain("drain_flush");

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = rnd_operand();
      b  = rnd_operand();
      issue(op, a, b, ref_result(op, a, b), 1'b1);
    end
    drain("drain_random");

    // Reset while calculating.
    issue(OP_DIV, 32'h1234_5678, 32'd13, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1 sys_reset = 1'b1;
    @(posedge clk);
    #1 sys_reset = 1'b0;
    @(negedge clk);
    chk("midreset_valid", 64'(m_div_wb_valid), 64'd0);
    chk("midreset_data", 64'(m_div_wb_data), 64'd0);
    chk("midreset_rd", 64'(m_div_wb_rd_id), 64'd0);
    chk("midreset_inst", 64'(m_div_wb_inst_id), 64'd0);
    chk("midreset_s_ready", 64'(s_div_ready), 64'd1);
    issue(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b1);
    drain("drain_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
